aludec_pipe: RTL and testbench
==============================

Name: aludec_pipe

Overview:
Registered, parametrised successor to the combinational ALU-control decoder of the MIPS core. It decodes op/funct/rt into an ALUCTRL_W-bit alucontrol word, including REGIMM branches (BLTZ/BGEZ/BLTZAL/BGEZAL) by rt and reserved-instruction detection. The decoded word is held in a valid/ready output register between ID and EX. A multi-cycle MULT/DIV occupancy tracker interlocks dependent HI/LO instructions.

Parameters:
ALUCTRL_W, 8, width of alucontrol (op encodings from defines2.vh, zero-extended if wider)
MUL_CYCLES, 1, EX occupancy of MULT/MULTU in cycles (>=1)
DIV_CYCLES, 36, EX occupancy of DIV/DIVU in cycles (>=1)
CNT_W, 6, tracker counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  ID holds a decodable instruction
in_ready  out  1  decoder accepts this cycle
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
rt  in  5  instr[20:16]
flush  in  1  squash the held output (branch/exception)
out_valid  out  1  alucontrol valid to EX
out_ready  in  1  EX consumes this cycle
alucontrol  out  ALUCTRL_W  registered decoded op
ri_exc  out  1  registered reserved-instruction flag
is_muldiv  out  1  registered: held op is MULT/MULTU/DIV/DIVU
md_busy  out  1  tracker non-idle
md_done  out  1  one-cycle pulse on last busy cycle

Behaviour:
- Reset (async, resetn=0): out_valid=0, alucontrol=EXE_NOP_OP (0), ri_exc=0, is_muldiv=0, tracker IDLE, counter=0, md_busy=0, md_done=0.
- Decode is combinational; the result is captured on an accept (in_valid && in_ready). Latency is 1 cycle from accept to out_valid.
- Decode rules:
  - I-type/J-type: same op mapping as the existing decoder.
  - op=000000 uses funct.
  - op=000001 uses rt: 00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL.
  - op=111111 -> all ones.
  - Any unlisted op/funct/rt -> alucontrol=EXE_NOP_OP, ri_exc=1. Never X.
- in_ready = !flush && (!out_valid || out_ready) && !interlock.
- interlock = md_busy && (incoming is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO) && !(md_done && decoder output stage empty-or-draining).
  - Simplification: interlock is held until the tracker returns to IDLE.
- Output register:
  - Load on accept.
  - Else clear out_valid on out_ready.
  - Hold all fields while out_valid && !out_ready.
- flush: next out_valid=0 and no accept that cycle. Flush wins over a simultaneous accept or consume.
- Tracker FSM, states IDLE / BUSY:
  - IDLE -> BUSY on a handoff (out_valid && out_ready && is_muldiv && !flush). Counter loads DIV_CYCLES-1 or MUL_CYCLES-1.
  - If the loaded value is 0, stay IDLE, pulse md_done next cycle, and set md_busy=0.
  - In BUSY the counter decrements each cycle. At counter==0: md_done=1 for that cycle, then IDLE.
  - Flush does not abort BUSY: an op already in EX completes.
  - A handoff is impossible while BUSY because the interlock prevents it.
- md_busy = (state==BUSY).
- Reset mid-BUSY returns the tracker to IDLE immediately with no md_done pulse.

Decomposition:
- Op/funct/rt codes and *_OP encodings come from the shared defines2.vh header. Add REGIMM rt codes and EXE_BLTZ/BGEZ/BLTZAL/BGEZAL_OP there.
- Sub-module md_tracker (FSM + counter, parametrised by MUL_CYCLES, DIV_CYCLES, CNT_W).
- Pure decode function aludec_comb in the same file.

Test Plan:
1. Reset, then ADD (op=000000, funct=100000) with in_valid=1, out_ready=1 -> next cycle out_valid=1, alucontrol=EXE_ADD_OP (8'b00100000), ri_exc=0.
2. op=000001, rt=10001 -> alucontrol=EXE_BGEZAL_OP. op=000001, rt=00111 -> alucontrol=0, ri_exc=1. op=000000, funct=111111 -> ri_exc=1, no X on any output.
3. Backpressure: out_ready=0 for 3 cycles after ANDI is held -> alucontrol stable, in_ready=0. Release -> ORI accepted the same cycle ANDI is consumed.
4. DIV handed off, then MFLO presented at in_valid -> md_busy=1 for 36 cycles, in_ready=0. md_done pulses in cycle 36. MFLO is accepted the cycle after.
5. flush while out_valid=1, out_ready=0 with a concurrent in_valid -> next cycle out_valid=0 and the input is not accepted. Flush during DIV BUSY -> counter continues and md_done still fires.
6. Assert resetn=0 during DIV BUSY (count=10) -> md_busy=0 and out_valid=0 immediately, no md_done. With MUL_CYCLES=1, MULT handoff -> md_done=1 next cycle, md_busy never 1.

Source files
------------

// File: rtl/aludec_pipe_pkg.sv
// ============================================================================
// Module : aludec_pipe_pkg
// Desc   : MIPS op/funct/rt codes, ALU-control encodings and decoder types.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aludec_pipe_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_SLTIU   = 6'b001011;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LB      = 6'b100000;
   localparam logic [5:0] OP_LH      = 6'b100001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_LBU     = 6'b100100;
   localparam logic [5:0] OP_LHU     = 6'b100101;
   localparam logic [5:0] OP_SB      = 6'b101000;
   localparam logic [5:0] OP_SH      = 6'b101001;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_ONES    = 6'b111111;

   // SPECIAL funct codes (instr[5:0])
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_SLLV  = 6'b000100;
   localparam logic [5:0] F_SRLV  = 6'b000110;
   localparam logic [5:0] F_SRAV  = 6'b000111;
   localparam logic [5:0] F_JR    = 6'b001000;
   localparam logic [5:0] F_JALR  = 6'b001001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   // REGIMM rt codes (instr[20:16])
   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   // ALU-control encodings
   localparam logic [7:0] EXE_NOP_OP    = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP    = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP     = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP    = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP    = 8'b00100111;
   localparam logic [7:0] EXE_ANDI_OP   = 8'b01011001;
   localparam logic [7:0] EXE_ORI_OP    = 8'b01011010;
   localparam logic [7:0] EXE_XORI_OP   = 8'b01011011;
   localparam logic [7:0] EXE_LUI_OP    = 8'b01011100;
   localparam logic [7:0] EXE_SLL_OP    = 8'b01111100;
   localparam logic [7:0] EXE_SLLV_OP   = 8'b00000100;
   localparam logic [7:0] EXE_SRL_OP    = 8'b00000010;
   localparam logic [7:0] EXE_SRLV_OP   = 8'b00000110;
   localparam logic [7:0] EXE_SRA_OP    = 8'b00000011;
   localparam logic [7:0] EXE_SRAV_OP   = 8'b00000111;
   localparam logic [7:0] EXE_MFHI_OP   = 8'b00010000;
   localparam logic [7:0] EXE_MTHI_OP   = 8'b00010001;
   localparam logic [7:0] EXE_MFLO_OP   = 8'b00010010;
   localparam logic [7:0] EXE_MTLO_OP   = 8'b00010011;
   localparam logic [7:0] EXE_SLT_OP    = 8'b00101010;
   localparam logic [7:0] EXE_SLTU_OP   = 8'b00101011;
   localparam logic [7:0] EXE_SLTI_OP   = 8'b01010111;
   localparam logic [7:0] EXE_SLTIU_OP  = 8'b01011000;
   localparam logic [7:0] EXE_ADD_OP    = 8'b00100000;
   localparam logic [7:0] EXE_ADDU_OP   = 8'b00100001;
   localparam logic [7:0] EXE_SUB_OP    = 8'b00100010;
   localparam logic [7:0] EXE_SUBU_OP   = 8'b00100011;
   localparam logic [7:0] EXE_ADDI_OP   = 8'b01010101;
   localparam logic [7:0] EXE_ADDIU_OP  = 8'b01010110;
   localparam logic [7:0] EXE_MULT_OP   = 8'b00011000;
   localparam logic [7:0] EXE_MULTU_OP  = 8'b00011001;
   localparam logic [7:0] EXE_DIV_OP    = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP   = 8'b00011011;
   localparam logic [7:0] EXE_J_OP      = 8'b01001111;
   localparam logic [7:0] EXE_JAL_OP    = 8'b01010000;
   localparam logic [7:0] EXE_JALR_OP   = 8'b00001001;
   localparam logic [7:0] EXE_JR_OP     = 8'b00001000;
   localparam logic [7:0] EXE_BEQ_OP    = 8'b01010001;
   localparam logic [7:0] EXE_BNE_OP    = 8'b01010010;
   localparam logic [7:0] EXE_BLEZ_OP   = 8'b01010011;
   localparam logic [7:0] EXE_BGTZ_OP   = 8'b01010100;
   localparam logic [7:0] EXE_BLTZ_OP   = 8'b01000000;
   localparam logic [7:0] EXE_BGEZ_OP   = 8'b01000001;
   localparam logic [7:0] EXE_BLTZAL_OP = 8'b01001010;
   localparam logic [7:0] EXE_BGEZAL_OP = 8'b01001011;
   localparam logic [7:0] EXE_LB_OP     = 8'b11100000;
   localparam logic [7:0] EXE_LBU_OP    = 8'b11100100;
   localparam logic [7:0] EXE_LH_OP     = 8'b11100001;
   localparam logic [7:0] EXE_LHU_OP    = 8'b11100101;
   localparam logic [7:0] EXE_LW_OP     = 8'b11100011;
   localparam logic [7:0] EXE_SB_OP     = 8'b11101000;
   localparam logic [7:0] EXE_SH_OP     = 8'b11101001;
   localparam logic [7:0] EXE_SW_OP     = 8'b11101011;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // all_ones marks the op=111111 case, which fills the full ALUCTRL_W width
   typedef struct packed {
      logic [7:0] code;
      logic       all_ones;
      logic       ri;
      logic       muldiv;
      logic       div;
      logic       hilo;
   } dec_t;

endpackage

`default_nettype wire

// File: rtl/aludec_pipe_if.sv
// ============================================================================
// Module : aludec_pipe_if
// Desc   : ID-side input handshake and EX-side output bundle of the decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface aludec_pipe_if #(
   parameter int ALUCTRL_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [5:0]           op;
   logic [5:0]           funct;
   logic [4:0]           rt;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [ALUCTRL_W-1:0] alucontrol;
   logic                 ri_exc;
   logic                 is_muldiv;
   logic                 md_busy;
   logic                 md_done;

   modport master (
      output in_valid, op, funct, rt, flush, out_ready,
      input  in_ready, out_valid, alucontrol, ri_exc, is_muldiv, md_busy, md_done
   );

   modport slave (
      input  in_valid, op, funct, rt, flush, out_ready,
      output in_ready, out_valid, alucontrol, ri_exc, is_muldiv, md_busy, md_done
   );
endinterface

`default_nettype wire

// File: rtl/aludec_pipe_md_tracker.sv
// ============================================================================
// Module : aludec_pipe_md_tracker
// Desc   : EX occupancy tracker for MULT/DIV; counts down the busy window.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aludec_pipe_md_tracker
   import aludec_pipe_pkg::*;
#(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 36,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic resetn,
   input  logic handoff,
   input  logic handoff_div,
   output logic md_busy,
   output logic md_done
);

   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

   md_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_zero_pulse;
   logic [CNT_W-1:0] w_load;

   assign w_load = handoff_div ? DIV_LOAD : MUL_LOAD;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= MD_IDLE;
         r_cnt        <= '0;
         r_zero_pulse <= 1'b0;
      end else begin
         r_zero_pulse <= 1'b0;
         case (r_state)
            MD_IDLE: begin
               if (handoff) begin
                  // single-cycle ops never enter BUSY, they only report completion
                  if (w_load == '0) begin
                     r_zero_pulse <= 1'b1;
                  end else begin
                     r_state <= MD_BUSY;
                     r_cnt   <= w_load;
                  end
               end
            end
            MD_BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= MD_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   assign md_busy = (r_state == MD_BUSY);
   assign md_done = ((r_state == MD_BUSY) && (r_cnt == '0)) || r_zero_pulse;

endmodule

`default_nettype wire

// File: rtl/aludec_pipe.sv
// ============================================================================
// Module : aludec_pipe
// Desc   : Registered MIPS ALU-control decoder with valid/ready output stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aludec_pipe
   import aludec_pipe_pkg::*;
#(
   parameter int ALUCTRL_W  = 8,
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 36,
   parameter int CNT_W      = 6
) (
   input  logic         clk,
   input  logic         resetn,
   aludec_pipe_if.slave bus
);

   function automatic dec_t aludec_comb(input logic [5:0] op, input logic [5:0] funct,
                                        input logic [4:0] rt);
      dec_t d;
      d = '0;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               F_SLL:   d.code = EXE_SLL_OP;
               F_SRL:   d.code = EXE_SRL_OP;
               F_SRA:   d.code = EXE_SRA_OP;
               F_SLLV:  d.code = EXE_SLLV_OP;
               F_SRLV:  d.code = EXE_SRLV_OP;
               F_SRAV:  d.code = EXE_SRAV_OP;
               F_JR:    d.code = EXE_JR_OP;
               F_JALR:  d.code = EXE_JALR_OP;
               F_MFHI:  begin d.code = EXE_MFHI_OP;  d.hilo = 1'b1; end
               F_MTHI:  begin d.code = EXE_MTHI_OP;  d.hilo = 1'b1; end
               F_MFLO:  begin d.code = EXE_MFLO_OP;  d.hilo = 1'b1; end
               F_MTLO:  begin d.code = EXE_MTLO_OP;  d.hilo = 1'b1; end
               F_MULT:  begin d.code = EXE_MULT_OP;  d.hilo = 1'b1; d.muldiv = 1'b1; end
               F_MULTU: begin d.code = EXE_MULTU_OP; d.hilo = 1'b1; d.muldiv = 1'b1; end
               F_DIV:   begin d.code = EXE_DIV_OP;   d.hilo = 1'b1; d.muldiv = 1'b1; d.div = 1'b1; end
               F_DIVU:  begin d.code = EXE_DIVU_OP;  d.hilo = 1'b1; d.muldiv = 1'b1; d.div = 1'b1; end
               F_ADD:   d.code = EXE_ADD_OP;
               F_ADDU:  d.code = EXE_ADDU_OP;
               F_SUB:   d.code = EXE_SUB_OP;
               F_SUBU:  d.code = EXE_SUBU_OP;
               F_AND:   d.code = EXE_AND_OP;
               F_OR:    d.code = EXE_OR_OP;
               F_XOR:   d.code = EXE_XOR_OP;
               F_NOR:   d.code = EXE_NOR_OP;
               F_SLT:   d.code = EXE_SLT_OP;
               F_SLTU:  d.code = EXE_SLTU_OP;
               default: d.ri = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ:   d.code = EXE_BLTZ_OP;
               RT_BGEZ:   d.code = EXE_BGEZ_OP;
               RT_BLTZAL: d.code = EXE_BLTZAL_OP;
               RT_BGEZAL: d.code = EXE_BGEZAL_OP;
               default:   d.ri = 1'b1;
            endcase
         end
         OP_J:     d.code = EXE_J_OP;
         OP_JAL:   d.code = EXE_JAL_OP;
         OP_BEQ:   d.code = EXE_BEQ_OP;
         OP_BNE:   d.code = EXE_BNE_OP;
         OP_BLEZ:  d.code = EXE_BLEZ_OP;
         OP_BGTZ:  d.code = EXE_BGTZ_OP;
         OP_ADDI:  d.code = EXE_ADDI_OP;
         OP_ADDIU: d.code = EXE_ADDIU_OP;
         OP_SLTI:  d.code = EXE_SLTI_OP;
         OP_SLTIU: d.code = EXE_SLTIU_OP;
         OP_ANDI:  d.code = EXE_ANDI_OP;
         OP_ORI:   d.code = EXE_ORI_OP;
         OP_XORI:  d.code = EXE_XORI_OP;
         OP_LUI:   d.code = EXE_LUI_OP;
         OP_LB:    d.code = EXE_LB_OP;
         OP_LH:    d.code = EXE_LH_OP;
         OP_LW:    d.code = EXE_LW_OP;
         OP_LBU:   d.code = EXE_LBU_OP;
         OP_LHU:   d.code = EXE_LHU_OP;
         OP_SB:    d.code = EXE_SB_OP;
         OP_SH:    d.code = EXE_SH_OP;
         OP_SW:    d.code = EXE_SW_OP;
         OP_ONES:  d.all_ones = 1'b1;
         default:  d.ri = 1'b1;
      endcase
      return d;
   endfunction

   dec_t                 w_dec;
   logic [ALUCTRL_W-1:0] w_ctrl;
   logic                 w_interlock;
   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_handoff;
   logic                 w_md_busy;
   logic                 w_md_done;

   logic                 r_out_valid;
   logic [ALUCTRL_W-1:0] r_alucontrol;
   logic                 r_ri_exc;
   logic                 r_is_muldiv;
   logic                 r_is_div;

   assign w_dec  = aludec_comb(bus.op, bus.funct, bus.rt);
   assign w_ctrl = w_dec.all_ones ? '1 : ALUCTRL_W'(w_dec.code);

   // HI/LO users wait for the tracker to go fully idle, including its md_done cycle
   assign w_interlock = w_md_busy && w_dec.hilo;
   assign w_in_ready  = !bus.flush && (!r_out_valid || bus.out_ready) && !w_interlock;
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_handoff   = r_out_valid && bus.out_ready && r_is_muldiv && !bus.flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_valid  <= 1'b0;
         r_alucontrol <= '0;
         r_ri_exc     <= 1'b0;
         r_is_muldiv  <= 1'b0;
         r_is_div     <= 1'b0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_alucontrol <= w_ctrl;
         r_ri_exc     <= w_dec.ri;
         r_is_muldiv  <= w_dec.muldiv;
         r_is_div     <= w_dec.div;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   aludec_pipe_md_tracker #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_tracker (
      .clk         (clk),
      .resetn      (resetn),
      .handoff     (w_handoff),
      .handoff_div (r_is_div),
      .md_busy     (w_md_busy),
      .md_done     (w_md_done)
   );

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.alucontrol = r_alucontrol;
   assign bus.ri_exc     = r_ri_exc;
   assign bus.is_muldiv  = r_is_muldiv;
   assign bus.md_busy    = w_md_busy;
   assign bus.md_done    = w_md_done;

endmodule

`default_nettype wire

// File: tb/tb_aludec_pipe.sv
// ============================================================================
// Module : tb_aludec_pipe
// Desc   : Directed self-checking bench for the registered ALU-control decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aludec_pipe;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   aludec_pipe_if #(.ALUCTRL_W(8)) bus ();

   aludec_pipe #(
      .ALUCTRL_W  (8),
      .MUL_CYCLES (1),
      .DIV_CYCLES (36),
      .CNT_W      (6)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   int   busy_n, done_n, done_at;
   logic ready_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic present(input logic v, input logic [5:0] op, input logic [5:0] funct,
                          input logic [4:0] rt);
      bus.in_valid = v;
      bus.op       = op;
      bus.funct    = funct;
      bus.rt       = rt;
   endtask

   // Walk the BUSY window with a cycle bound, optionally flushing its first cycles
   task automatic run_busy(input int flush_n, output int busy, output int dones,
                           output int at, output logic rdy);
      busy = 0; dones = 0; at = 0; rdy = 1'b0;
      while (bus.md_busy && busy < 60) begin
         busy++;
         bus.flush = (busy <= flush_n);
         #1;
         if (bus.md_done) begin
            dones++;
            at = busy;
         end
         if (bus.in_ready) rdy = 1'b1;
         tick;
      end
      bus.flush = 1'b0;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      present(1'b0, 6'd0, 6'd0, 5'd0);

      // reset state
      #3;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_alucontrol", bus.alucontrol, 0);
      check("rst_ri_exc", bus.ri_exc, 0);
      check("rst_is_muldiv", bus.is_muldiv, 0);
      check("rst_md_busy", bus.md_busy, 0);
      check("rst_md_done", bus.md_done, 0);
      tick; tick;
      resetn = 1'b1;

      // ADD with 1-cycle latency
      bus.out_ready = 1'b1;
      present(1'b1, 6'b000000, 6'b100000, 5'd0);
      #1 check("add_in_ready", bus.in_ready, 1);
      tick;
      check("add_valid", bus.out_valid, 1);
      check("add_ctrl", bus.alucontrol, 8'b00100000);
      check("add_ri", bus.ri_exc, 0);
      check("add_muldiv", bus.is_muldiv, 0);

      // REGIMM, reserved and special ops
      present(1'b1, 6'b000001, 6'd0, 5'b10001);
      tick;
      check("bgezal_ctrl", bus.alucontrol, 8'b01001011);
      check("bgezal_ri", bus.ri_exc, 0);
      present(1'b1, 6'b000001, 6'd0, 5'b00111);
      tick;
      check("regimm_rsv_ctrl", bus.alucontrol, 0);
      check("regimm_rsv_ri", bus.ri_exc, 1);
      present(1'b1, 6'b000000, 6'b111111, 5'd0);
      tick;
      check("funct_rsv_ri", bus.ri_exc, 1);
      check("funct_rsv_ctrl", bus.alucontrol, 0);
      check("no_x", 32'($isunknown({bus.out_valid, bus.alucontrol, bus.ri_exc, bus.is_muldiv,
                                    bus.md_busy, bus.md_done, bus.in_ready})), 0);
      present(1'b1, 6'b111111, 6'd0, 5'd0);
      tick;
      check("ones_ctrl", bus.alucontrol, 8'hFF);
      check("ones_ri", bus.ri_exc, 0);
      present(1'b1, 6'b100011, 6'd0, 5'd0);
      tick;
      check("lw_ctrl", bus.alucontrol, 8'b11100011);

      // backpressure: ANDI held, ORI waits
      present(1'b1, 6'b001100, 6'd0, 5'd0);
      tick;
      check("andi_ctrl", bus.alucontrol, 8'b01011001);
      bus.out_ready = 1'b0;
      present(1'b1, 6'b001101, 6'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         #1 check("bp_in_ready", bus.in_ready, 0);
         tick;
         check("bp_hold_ctrl", bus.alucontrol, 8'b01011001);
         check("bp_hold_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      #1 check("release_in_ready", bus.in_ready, 1);
      tick;
      check("ori_ctrl", bus.alucontrol, 8'b01011010);
      check("ori_valid", bus.out_valid, 1);
      present(1'b0, 6'd0, 6'd0, 5'd0);
      tick;
      check("drain_valid", bus.out_valid, 0);

      // DIV handoff, MFLO interlocked for the whole busy window
      present(1'b1, 6'b000000, 6'b011010, 5'd0);
      tick;
      check("div_muldiv", bus.is_muldiv, 1);
      check("div_busy_pre", bus.md_busy, 0);
      present(1'b0, 6'd0, 6'd0, 5'd0);
      tick;
      check("div_busy", bus.md_busy, 1);
      present(1'b1, 6'b000000, 6'b010010, 5'd0);
      run_busy(0, busy_n, done_n, done_at, ready_seen);
      check("div_busy_cycles", busy_n, 36);
      check("div_done_count", done_n, 1);
      check("div_done_at", done_at, 36);
      check("mflo_blocked", ready_seen, 0);
      #1 check("mflo_ready", bus.in_ready, 1);
      tick;
      check("mflo_valid", bus.out_valid, 1);
      check("mflo_ctrl", bus.alucontrol, 8'b00010010);

      // flush against held output plus new input
      bus.out_ready = 1'b0;
      present(1'b1, 6'b000000, 6'b100000, 5'd0);
      bus.flush = 1'b1;
      #1 check("flush_in_ready", bus.in_ready, 0);
      tick;
      bus.flush = 1'b0;
      present(1'b0, 6'd0, 6'd0, 5'd0);
      check("flush_valid", bus.out_valid, 0);
      check("flush_no_load", bus.alucontrol, 8'b00010010);

      // flush does not abort a DIV already in EX
      bus.out_ready = 1'b1;
      present(1'b1, 6'b000000, 6'b011010, 5'd0);
      tick;
      present(1'b0, 6'd0, 6'd0, 5'd0);
      tick;
      check("div2_busy", bus.md_busy, 1);
      run_busy(3, busy_n, done_n, done_at, ready_seen);
      check("flush_div_cycles", busy_n, 36);
      check("flush_div_done", done_n, 1);

      // reset in the middle of a DIV (counter at 10)
      present(1'b1, 6'b000000, 6'b011010, 5'd0);
      tick;
      present(1'b1, 6'b000000, 6'b100000, 5'd0);
      tick;
      bus.out_ready = 1'b0;
      present(1'b0, 6'd0, 6'd0, 5'd0);
      repeat (25) tick;
      check("pre_rst_busy", bus.md_busy, 1);
      check("pre_rst_valid", bus.out_valid, 1);
      resetn = 1'b0;
      #1;
      check("rst_mid_busy", bus.md_busy, 0);
      check("rst_mid_valid", bus.out_valid, 0);
      check("rst_mid_done", bus.md_done, 0);
      tick;
      check("rst_hold_done", bus.md_done, 0);
      resetn = 1'b1;

      // single-cycle MULT: done pulse without BUSY
      bus.out_ready = 1'b1;
      present(1'b1, 6'b000000, 6'b011000, 5'd0);
      tick;
      check("mult_muldiv", bus.is_muldiv, 1);
      check("mult_busy0", bus.md_busy, 0);
      present(1'b0, 6'd0, 6'd0, 5'd0);
      tick;
      check("mult_done", bus.md_done, 1);
      check("mult_busy1", bus.md_busy, 0);
      tick;
      check("mult_done_end", bus.md_done, 0);
      check("mult_busy2", bus.md_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
